// File: rtl/sdf_delay_line_if.sv
// Sample/status bundle between a radix-2 SDF butterfly stage and its feedback delay line.
interface sdf_delay_line_if #(
    parameter int DW    = 24,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(2 * DEPTH);

    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;
    logic                 dout_valid;
    logic                 busy;
    logic [CW-1:0]        phase_cnt;
    logic                 phase_hi;

    modport master (
        output in_valid, din_r, din_i,
        input  dout_r, dout_i, dout_valid, busy, phase_cnt, phase_hi
    );

    modport slave (
        input  in_valid, din_r, din_i,
        output dout_r, dout_i, dout_valid, busy, phase_cnt, phase_hi
    );
endinterface

// File: rtl/sdf_delay_line.sv
// Parametrised complex feedback delay line for a radix-2 SDF FFT stage, with valid tracking,
// zero-fill drain and a stage phase counter. Define SDF_DELAY_OCC_EN to add the occupancy output.
module sdf_delay_line #(
    parameter int DW    = 24,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    sdf_delay_line_if.slave                dl
`ifdef SDF_DELAY_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
`endif
);
    localparam int CW  = $clog2(2 * DEPTH);
    localparam int DCW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]        phase_q, phase_d;
    logic [DEPTH-1:0]     valid_q;
    logic signed [DW-1:0] re_q [DEPTH];
    logic signed [DW-1:0] im_q [DEPTH];
    logic                 shift_en;

    assign shift_en = dl.in_valid | (state_q != IDLE);

    // Data is zeroed when no sample is presented so the drain flushes clean zeros to the twiddle stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (clear) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (shift_en) begin
            valid_q <= {valid_q[DEPTH-2:0], dl.in_valid};
            re_q[0] <= dl.in_valid ? dl.din_r : '0;
            im_q[0] <= dl.in_valid ? dl.din_i : '0;
            for (int k = 1; k < DEPTH; k++) begin
                re_q[k] <= re_q[k-1];
                im_q[k] <= im_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        phase_d     = phase_q;
        if (clear) begin
            state_d     = IDLE;
            drain_cnt_d = '0;
            phase_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dl.in_valid) state_d = RUN;
                end
                RUN: begin
                    if (!dl.in_valid) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                DRAIN: begin
                    if (dl.in_valid) begin
                        state_d     = RUN;
                        drain_cnt_d = '0;
                    end else if (drain_cnt_q == DCW'(DEPTH - 1)) begin
                        state_d = IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (shift_en) begin
                phase_d = (phase_q == CW'(2 * DEPTH - 1)) ? '0 : phase_q + 1'b1;
            end
            // Each new burst starts its butterfly phase from zero.
            if (state_q != IDLE && state_d == IDLE) phase_d = '0;
        end
    end

`ifdef SDF_DELAY_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);
    logic [OW-1:0] occ_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else if (clear) begin
            occ_q <= '0;
        end else if (shift_en) begin
            if (dl.in_valid && !valid_q[DEPTH-1]) occ_q <= occ_q + 1'b1;
            else if (!dl.in_valid && valid_q[DEPTH-1]) occ_q <= occ_q - 1'b1;
        end
    end

    assign occupancy = occ_q;
`endif

    assign dl.dout_r     = re_q[DEPTH-1];
    assign dl.dout_i     = im_q[DEPTH-1];
    assign dl.dout_valid = valid_q[DEPTH-1];
    assign dl.busy       = (state_q != IDLE);
    assign dl.phase_cnt  = phase_q;
    assign dl.phase_hi   = (phase_q >= CW'(DEPTH));
endmodule
